// File: rtl/sid_wr_bridge.sv
// sid_wr_bridge
// Turns a stream of SPI bytes into paced SID register writes.
// A byte with bit 7 set selects the target register and carries the top two
// data bits. Each following byte with bit 7 clear supplies the low six data
// bits and queues one write to the selected register. Queued writes are sent
// to the SID one at a time. Each write spans exactly one 1 MHz CLKen pulse.
//
// Ports
//   CLK       in   system clock (12 MHz); all logic runs on its rising edge
//   RST       in   synchronous active-high reset
//   SPI_DATA  in   received SPI byte, valid while SPI_RECV is high
//   SPI_RECV  in   one-cycle strobe: a byte has been received
//   CLKen     in   1 MHz SID clock enable, one CLK cycle high per 12
//   WR        out  SID register write strobe
//   ADDR      out  SID register address
//   DATAW     out  SID write data
//   LEVEL     out  FIFO occupancy, including the write currently on WR
//   OVF       out  sticky flag: a push was dropped (optional)
//   DROP_CNT  out  dropped-push count, saturating at 255 (optional)
//
// Configuration
//   SID_WR_BRIDGE_OVF_STATUS_EN  when defined, adds the OVF and DROP_CNT
//                                outputs. The drop behaviour is the same
//                                with or without this macro.
module sid_wr_bridge #(
  parameter int DEPTH = 16
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [7:0]             SPI_DATA,
  input  logic                   SPI_RECV,
  input  logic                   CLKen,
  output logic                   WR,
  output logic [4:0]             ADDR,
  output logic [7:0]             DATAW,
  output logic [$clog2(DEPTH):0] LEVEL
`ifdef SID_WR_BRIDGE_OVF_STATUS_EN
  ,
  output logic                   OVF,
  output logic [7:0]             DROP_CNT
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FullLevel = (AW+1)'(DEPTH);

  typedef enum logic {
    NOADDR,
    ADDRVALID
  } state_t;

  state_t        state_q, state_d;
  logic [4:0]    addr_q, addr_d;
  logic [1:0]    hi_q, hi_d;
  logic [AW-1:0] wrPtr_q, wrPtr_d;
  logic [AW-1:0] rdPtr_q, rdPtr_d;
  logic [AW:0]   level_q, level_d;
  logic          wr_q, wr_d;
  logic [4:0]    addrOut_q, addrOut_d;
  logic [7:0]    dataOut_q, dataOut_d;

  // Each entry is {address[4:0], data[7:0]}.
  logic [12:0]   mem [DEPTH];

  logic          pushReq;
  logic          pushOk;
  logic          popDone;
  logic          issue;
  logic          drop;
  logic          full;
  logic [12:0]   pushEntry;
  logic [12:0]   headEntry;

`ifdef SID_WR_BRIDGE_OVF_STATUS_EN
  logic          ovf_q, ovf_d;
  logic [7:0]    dropCnt_q, dropCnt_d;
`endif

  // Byte decoder, FIFO bookkeeping and write sequencer.
  // The entry on WR keeps its FIFO slot until its CLKen pulse is consumed.
  // It is popped only then. So LEVEL counts the write in flight, and the
  // full FIFO can accept a push in the same cycle the write completes.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    hi_d      = hi_q;
    wrPtr_d   = wrPtr_q;
    rdPtr_d   = rdPtr_q;
    level_d   = level_q;
    wr_d      = wr_q;
    addrOut_d = addrOut_q;
    dataOut_d = dataOut_q;
    pushReq   = 1'b0;
    pushEntry = {addr_q, hi_q, SPI_DATA[5:0]};
    headEntry = mem[rdPtr_q];

    if (SPI_RECV) begin
      if (SPI_DATA[7]) begin
        addr_d  = SPI_DATA[6:2];
        hi_d    = SPI_DATA[1:0];
        state_d = ADDRVALID;
      end else if (state_q == ADDRVALID) begin
        pushReq = 1'b1;
      end
    end

    full    = (level_q == FullLevel);
    popDone = wr_q && CLKen;
    issue   = !wr_q && (level_q != '0);
    pushOk  = pushReq && (!full || popDone);
    drop    = pushReq && full && !popDone;

    if (pushOk) begin
      wrPtr_d = wrPtr_q + AW'(1);
    end

    if (popDone) begin
      rdPtr_d = rdPtr_q + AW'(1);
      wr_d    = 1'b0;
    end else if (issue) begin
      wr_d      = 1'b1;
      addrOut_d = headEntry[12:8];
      dataOut_d = headEntry[7:0];
    end

    if (pushOk && !popDone) begin
      level_d = level_q + (AW+1)'(1);
    end else if (!pushOk && popDone) begin
      level_d = level_q - (AW+1)'(1);
    end
  end

  // State register with synchronous reset. Reset takes priority over any
  // byte or CLKen arriving in the same cycle. A write in flight is abandoned
  // and is not reissued.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= NOADDR;
      addr_q    <= '0;
      hi_q      <= '0;
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
      level_q   <= '0;
      wr_q      <= 1'b0;
      addrOut_q <= '0;
      dataOut_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      hi_q      <= hi_d;
      wrPtr_q   <= wrPtr_d;
      rdPtr_q   <= rdPtr_d;
      level_q   <= level_d;
      wr_q      <= wr_d;
      addrOut_q <= addrOut_d;
      dataOut_q <= dataOut_d;
    end
  end

  // FIFO storage. The array needs no reset because the pointers and the
  // level decide which entries are valid.
  always_ff @(posedge CLK) begin
    if (!RST && pushOk) begin
      mem[wrPtr_q] <= pushEntry;
    end
  end

`ifdef SID_WR_BRIDGE_OVF_STATUS_EN
  // Overflow status. It is sticky, and only reset clears it.
  always_comb begin
    ovf_d     = ovf_q | drop;
    dropCnt_d = dropCnt_q;
    if (drop && (dropCnt_q != 8'hFF)) begin
      dropCnt_d = dropCnt_q + 8'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      ovf_q     <= 1'b0;
      dropCnt_q <= '0;
    end else begin
      ovf_q     <= ovf_d;
      dropCnt_q <= dropCnt_d;
    end
  end

  assign OVF      = ovf_q;
  assign DROP_CNT = dropCnt_q;
`endif

  assign WR    = wr_q;
  assign ADDR  = addrOut_q;
  assign DATAW = dataOut_q;
  assign LEVEL = level_q;

endmodule

// File: tb/tb_sid_wr_bridge.sv
// tb_sid_wr_bridge
// This bench drives sid_wr_bridge with directed SPI byte sequences.
// Each expected SID write is pushed onto a queue when its byte is issued.
// A monitor pops and compares the queue each time WR rises. The monitor also
// checks that ADDR and DATAW stay stable while WR is high, and that each
// write spans exactly one CLKen pulse.
module tb_sid_wr_bridge;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [7:0] SPI_DATA = 8'h00;
  logic       SPI_RECV = 1'b0;
  logic       CLKen = 1'b0;
  logic       WR;
  logic [4:0] ADDR;
  logic [7:0] DATAW;
  logic [4:0] LEVEL;
`ifdef SID_WR_BRIDGE_OVF_STATUS_EN
  logic       OVF;
  logic [7:0] DROP_CNT;
`endif

  int nVectors = 0;
  int nFails = 0;
  logic [12:0] sbQ[$];

  int   clkMode = 0;
  logic forceEn = 1'b0;

  sid_wr_bridge #(.DEPTH(16)) dut (
    .CLK(CLK),
    .RST(RST),
    .SPI_DATA(SPI_DATA),
    .SPI_RECV(SPI_RECV),
    .CLKen(CLKen),
    .WR(WR),
    .ADDR(ADDR),
    .DATAW(DATAW),
    .LEVEL(LEVEL)
`ifdef SID_WR_BRIDGE_OVF_STATUS_EN
    ,
    .OVF(OVF),
    .DROP_CNT(DROP_CNT)
`endif
  );

  // 100 MHz bench clock. The design does not depend on the absolute rate.
  initial begin
    forever #5 CLK = ~CLK;
  end

  // CLKen source.
  //   clkMode 1: one pulse every 12 cycles.
  //   clkMode 0: CLKen follows forceEn.
  // It updates at #2 after each edge, after the main stimulus at #1.
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(posedge CLK);
      #2;
      if (clkMode == 1) begin
        cnt = (cnt == 11) ? 0 : cnt + 1;
        CLKen = (cnt == 0);
      end else begin
        cnt = 0;
        CLKen = forceEn;
      end
    end
  end

  // Global watchdog so that the bench always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation still running at time limit, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nVectors++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    @(posedge CLK);
    #1;
    SPI_DATA = b;
    SPI_RECV = 1'b1;
    @(posedge CLK);
    #1;
    SPI_RECV = 1'b0;
  endtask

  task automatic expectWrite(input logic [4:0] a, input logic [7:0] d);
    sbQ.push_back({a, d});
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic doReset();
    @(posedge CLK);
    #1;
    RST = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    sbQ.delete();
  endtask

  task automatic waitDrain(input string name, input int maxCycles);
    int i;
    for (i = 0; i < maxCycles; i++) begin
      @(negedge CLK);
      if (sbQ.size() == 0 && WR === 1'b0 && LEVEL === 5'd0) break;
    end
    checkOutput(name, (i < maxCycles) ? 32'd1 : 32'd0, 32'd1);
    waitCycles(2);
  endtask

  // Monitor. When WR rises, it takes the next expected write and compares
  // ADDR and DATAW. While WR stays high, it checks that ADDR and DATAW are
  // stable and counts the CLKen pulses. When WR falls, it requires that
  // count to be exactly one. A reset closes any open write window.
  initial begin
    bit          window;
    int          pulses;
    logic [4:0]  holdAddr;
    logic [7:0]  holdData;
    logic [12:0] exp;
    window = 0;
    pulses = 0;
    holdAddr = '0;
    holdData = '0;
    forever begin
      @(negedge CLK);
      if (RST) begin
        window = 0;
        pulses = 0;
      end else if (!window) begin
        if (WR === 1'b1) begin
          window = 1;
          pulses = (CLKen === 1'b1) ? 1 : 0;
          holdAddr = ADDR;
          holdData = DATAW;
          if (sbQ.size() == 0) begin
            nVectors++;
            nFails++;
            $display("[TB] FAIL unexpected write: got ADDR=0x%0h DATAW=0x%0h, required no write", ADDR, DATAW);
          end else begin
            exp = sbQ.pop_front();
            checkOutput("write ADDR", {27'd0, ADDR}, {27'd0, exp[12:8]});
            checkOutput("write DATAW", {24'd0, DATAW}, {24'd0, exp[7:0]});
          end
        end
      end else begin
        if (WR === 1'b1) begin
          checkOutput("ADDR hold", {27'd0, ADDR}, {27'd0, holdAddr});
          checkOutput("DATAW hold", {24'd0, DATAW}, {24'd0, holdData});
          if (CLKen === 1'b1) pulses++;
        end else begin
          checkOutput("CLKen pulses per write", pulses, 1);
          window = 0;
        end
      end
    end
  end

  initial begin
    logic [7:0] b;
    logic [4:0] a;
    logic [1:0] hi;
    int         guard;

    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b0;
    @(negedge CLK);
    checkOutput("reset WR", {31'd0, WR}, 32'd0);
    checkOutput("reset ADDR", {27'd0, ADDR}, 32'd0);
    checkOutput("reset DATAW", {24'd0, DATAW}, 32'd0);
    checkOutput("reset LEVEL", {27'd0, LEVEL}, 32'd0);
`ifdef SID_WR_BRIDGE_OVF_STATUS_EN
    checkOutput("reset OVF", {31'd0, OVF}, 32'd0);
    checkOutput("reset DROP_CNT", {24'd0, DROP_CNT}, 32'd0);
`endif

    // 0x93 selects register 4 with top data bits 2'b11.
    // 0x05 then writes the data 0xC5.
    $display("[TB] basic write 0x93, 0x05");
    clkMode = 1;
    expectWrite(5'h04, 8'hC5);
    applyStimulus(8'h93);
    checkOutput("LEVEL after address byte", {27'd0, LEVEL}, 32'd0);
    applyStimulus(8'h05);
    checkOutput("LEVEL after data byte", {27'd0, LEVEL}, 32'd1);
    waitDrain("basic write drained", 200);

    // A data byte received before any address byte is discarded.
    $display("[TB] data byte without address, then 0x80 0x01 0x02");
    doReset();
    applyStimulus(8'h2A);
    waitCycles(30);
    checkOutput("LEVEL after orphan byte", {27'd0, LEVEL}, 32'd0);
    expectWrite(5'h00, 8'h01);
    expectWrite(5'h00, 8'h02);
    applyStimulus(8'h80);
    applyStimulus(8'h01);
    applyStimulus(8'h02);
    waitDrain("two writes drained", 300);

    // Hold CLKen low and push 20 data bytes. The first 16 fit: one on WR
    // plus 15 queued. The remaining 4 are dropped.
    // 0xA1 selects register 8 with top data bits 2'b01.
    $display("[TB] overflow with CLKen held low");
    clkMode = 0;
    waitCycles(2);
    for (int i = 0; i < 16; i++) expectWrite(5'h08, 8'h40 | 8'(i));
    applyStimulus(8'hA1);
    for (int i = 0; i < 20; i++) applyStimulus(8'(i));
    waitCycles(2);
    checkOutput("LEVEL when full", {27'd0, LEVEL}, 32'd16);
    checkOutput("WR in flight when full", {31'd0, WR}, 32'd1);
`ifdef SID_WR_BRIDGE_OVF_STATUS_EN
    checkOutput("OVF after drops", {31'd0, OVF}, 32'd1);
    checkOutput("DROP_CNT after drops", {24'd0, DROP_CNT}, 32'd4);
`endif

    // While the FIFO is full, send a push in the same cycle as the CLKen
    // pulse that completes the in-flight write. The push is accepted.
    $display("[TB] full FIFO push coinciding with pop");
    expectWrite(5'h08, 8'h7F);
    @(posedge CLK);
    #1;
    SPI_DATA = 8'h3F;
    SPI_RECV = 1'b1;
    forceEn = 1'b1;
    @(posedge CLK);
    #1;
    SPI_RECV = 1'b0;
    forceEn = 1'b0;
    checkOutput("LEVEL after push+pop", {27'd0, LEVEL}, 32'd16);
    checkOutput("WR after completing write", {31'd0, WR}, 32'd0);
`ifdef SID_WR_BRIDGE_OVF_STATUS_EN
    checkOutput("DROP_CNT after push+pop", {24'd0, DROP_CNT}, 32'd4);
`endif
    clkMode = 1;
    waitDrain("full FIFO drained", 1000);

    // Reset while a write is in flight and 5 entries are held.
    $display("[TB] reset with write in flight");
    doReset();
    clkMode = 0;
    waitCycles(2);
    for (int i = 1; i <= 5; i++) expectWrite(5'h01, 8'(i));
    applyStimulus(8'h84);
    for (int i = 1; i <= 5; i++) applyStimulus(8'(i));
    waitCycles(2);
    checkOutput("WR before reset", {31'd0, WR}, 32'd1);
    checkOutput("LEVEL before reset", {27'd0, LEVEL}, 32'd5);
    doReset();
    checkOutput("WR after reset", {31'd0, WR}, 32'd0);
    checkOutput("LEVEL after reset", {27'd0, LEVEL}, 32'd0);
    checkOutput("ADDR after reset", {27'd0, ADDR}, 32'd0);
    checkOutput("DATAW after reset", {24'd0, DATAW}, 32'd0);
`ifdef SID_WR_BRIDGE_OVF_STATUS_EN
    checkOutput("OVF after reset", {31'd0, OVF}, 32'd0);
`endif
    clkMode = 1;
    applyStimulus(8'h11);
    waitCycles(60);
    checkOutput("LEVEL idle after reset", {27'd0, LEVEL}, 32'd0);
    checkOutput("WR idle after reset", {31'd0, WR}, 32'd0);

    // Send 40 writes with a new address every 10 bytes. The pointers wrap
    // twice. Bit 6 of the data bytes is toggled and must have no effect.
    $display("[TB] 40 writes with pointer wrap");
    doReset();
    clkMode = 1;
    a = 5'd0;
    hi = 2'd0;
    for (int i = 0; i < 40; i++) begin
      if (i % 10 == 0) begin
        a = 5'(i / 10 + 3);
        hi = 2'(i / 10);
        b = {1'b1, a, hi};
        applyStimulus(b);
      end
      guard = 0;
      while (LEVEL >= 5'd14 && guard < 400) begin
        @(posedge CLK);
        #1;
        guard++;
      end
      if (guard >= 400) checkOutput("flow control wait", guard, 0);
      b = {1'b0, 1'(i), 6'(i)};
      expectWrite(a, {hi, 6'(i)});
      applyStimulus(b);
    end
    waitDrain("wrap sequence drained", 2000);

    waitCycles(5);
    checkOutput("scoreboard empty", sbQ.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nFails);
    $finish;
  end

endmodule
